// File: rtl/dw_mac_sequencer.sv
// dw_mac_sequencer: feeds one depthwise window of activation/weight pairs
// into an external fixed-point multiplier and sums the returning products
// into a full-precision accumulator, also presenting a saturated copy.
module dw_mac_sequencer #(
    parameter int bitsize   = 14,
    parameter int FRAC_BITS = 9,
    parameter int TAPS      = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [bitsize-1:0]                  data_in,
    input  logic [bitsize-1:0]                  weight_in,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                mul_start,
    output logic [bitsize-1:0]                  mul_a,
    output logic [bitsize-1:0]                  mul_b,
    input  logic [2*bitsize-FRAC_BITS-1:0]      mul_result,
    input  logic                                mul_valid,
    output logic [2*bitsize-FRAC_BITS+3:0]      acc_result,
    output logic [bitsize-1:0]                  sat_result,
    output logic                                out_valid,
    output logic                                busy
);

    localparam int PW = 2*bitsize - FRAC_BITS;
    localparam int AW = PW + 4;
    localparam int CW = $clog2(TAPS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Saturation bounds, both in accumulator width and in word width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-bitsize+1){1'b0}}, {(bitsize-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-bitsize+1){1'b1}}, {(bitsize-1){1'b0}}};
    localparam logic [bitsize-1:0]   SAT_HI  = {1'b0, {(bitsize-1){1'b1}}};
    localparam logic [bitsize-1:0]   SAT_LO  = {1'b1, {(bitsize-1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic [CW-1:0]            issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]            ret_cnt_q, ret_cnt_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic [bitsize-1:0]       mul_a_q, mul_a_d;
    logic [bitsize-1:0]       mul_b_q, mul_b_d;
    logic                     mul_start_q, mul_start_d;
    logic                     accept_pair;
    logic                     retire_product;
    logic [bitsize-1:0]       sat_value;

    assign accept_pair    = (state_q == FEED) && in_valid;
    assign retire_product = ((state_q == FEED) || (state_q == DRAIN)) && mul_valid;

    // Next-state logic: issue pairs while feeding, fold returning products in
    // whenever a window is open, and leave DRAIN on the final return.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        acc_d       = acc_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;

        if (retire_product) begin
            acc_d     = acc_q + {{(AW-PW){mul_result[PW-1]}}, mul_result};
            ret_cnt_d = ret_cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FEED;
                    acc_d       = '0;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            FEED: begin
                if (accept_pair) begin
                    mul_a_d     = data_in;
                    mul_b_d     = weight_in;
                    mul_start_d = 1'b1;
                    issue_cnt_d = issue_cnt_q + CW'(1);
                    if (issue_cnt_q == CW'(TAPS - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ret_cnt_d == CW'(TAPS)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            acc_q       <= acc_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
        end
    end

    // Clamp the full-precision sum into the signed word range; the binary
    // point is shared, so the in-range case is a plain truncation.
    always_comb begin
        sat_value = acc_q[bitsize-1:0];
        if (acc_q > SAT_MAX) begin
            sat_value = SAT_HI;
        end else if (acc_q < SAT_MIN) begin
            sat_value = SAT_LO;
        end
    end

    assign in_ready   = (state_q == FEED);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign acc_result = acc_q;
    assign sat_result = sat_value;

endmodule

// File: doc/dw_mac_sequencer.md
DW_MAC_SEQUENCER -- requirements
Module: dw_mac_sequencer

Interface
REQ-001 SHALL have parameter bitsize, default 14, meaning the signed width of activation and weight words.
REQ-002 SHALL have parameter FRAC_BITS, default 9, meaning the fractional bits of every fixed-point word.
REQ-003 SHALL have parameter TAPS, default 9, meaning the products accumulated per window (3x3 depthwise kernel); legal range 1..16.
REQ-004 SHALL derive localparams PW = 2*bitsize-FRAC_BITS (product width, 19) and AW = PW+4 (accumulator width, 23).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 start  input  1  begin one window; sampled only in IDLE.
REQ-008 data_in  input  bitsize  signed activation, Q(bitsize-FRAC_BITS).FRAC_BITS.
REQ-009 weight_in  input  bitsize  signed weight, same format.
REQ-010 in_valid  input  1  data_in/weight_in pair valid.
REQ-011 in_ready  output  1  sequencer accepts a pair this cycle.
REQ-012 mul_start  output  1  issue strobe to the fixed_point_multiplier start_flag.
REQ-013 mul_a, mul_b  output  bitsize each  multiplier operands.
REQ-014 mul_result  input  PW  signed multiplier product, FRAC_BITS fractional bits.
REQ-015 mul_valid  input  1  mul_result valid this cycle.
REQ-016 acc_result  output  AW  signed full-precision window sum.
REQ-017 sat_result  output  bitsize  acc_result clamped to signed bitsize range.
REQ-018 out_valid  output  1  one-cycle pulse; results valid.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-021 IDLE: start=1 -> FEED; accumulator, issue_cnt and ret_cnt cleared on that edge.
REQ-022 FEED: in_ready=1; each cycle with in_valid=1 SHALL register mul_a=data_in, mul_b=weight_in, assert mul_start for exactly that next cycle, and increment issue_cnt.
REQ-023 FEED: when the TAPS-th pair is accepted -> DRAIN; in_ready=0 in every state except FEED.
REQ-024 in_valid=0 in FEED SHALL produce mul_start=0 (bubbles allowed, no timeout).
REQ-025 Every mul_valid=1 in FEED or DRAIN SHALL add sign-extended mul_result to the accumulator and increment ret_cnt; mul_valid in IDLE or DONE SHALL be ignored.
REQ-026 Accept and accumulate in the same cycle SHALL both take effect.
REQ-027 DRAIN: when ret_cnt reaches TAPS (including the edge of the final mul_valid) -> DONE; block SHALL tolerate any multiplier latency >=1.
REQ-028 DONE: out_valid=1 for exactly one cycle with acc_result and sat_result stable, then -> IDLE.
REQ-029 acc_result and sat_result SHALL hold their values after DONE until the next start.
REQ-030 sat_result = 2^(bitsize-1)-1 if acc_result > that, -2^(bitsize-1) if acc_result < that, else acc_result[bitsize-1:0]; no rescaling (same FRAC_BITS).
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 Minimum window latency, start to out_valid, SHALL be TAPS+L+2 cycles for multiplier latency L and in_valid held high.

Reset
REQ-033 rst=0 at a rising edge SHALL force IDLE and zero acc_result, sat_result, out_valid, busy, in_ready, mul_start, mul_a, mul_b, issue_cnt, ret_cnt.
REQ-034 Reset mid-window SHALL discard the partial sum; late mul_valid after reset release SHALL be ignored (state IDLE).

Verification
REQ-035 Nominal: TAPS=9, 9 pairs a=512 (1.0), b=256 (0.5), in_valid held -> 9 mul_start pulses, out_valid once, acc_result=2304, sat_result=2304.
REQ-036 Positive saturation: 9 pairs a=7680 (15.0), b=7680 -> acc_result=1036800, sat_result=8191.
REQ-037 Negative saturation: 9 pairs a=-8192 (-16.0), b=7680 -> acc_result=-1105920, sat_result=-8192.
REQ-038 Bubbles: in_valid toggled 1,0,1,0... with a=512, b=512 -> exactly 9 mul_start pulses, acc_result=4608, out_valid single cycle.
REQ-039 Reset mid-window: rst=0 after 4 pairs accepted -> all outputs 0, state IDLE; new window of 9x(512,256) -> acc_result=2304.
REQ-040 Ignored start: start pulsed during FEED and DRAIN -> no restart, single out_valid, acc_result unchanged from nominal.
